// File: rtl/decode_onehot_scan_pkg.sv
// Shared definitions for the one-hot decoder / scanner.
//   MODE_DECODE / MODE_SCAN : encodings of the mode input
//   MAX_IN_W / MAX_OUT_W    : widest index the onehot() helper supports
//   onehot(idx)             : MAX_OUT_W-bit one-hot of idx; callers truncate
//                             to their own output width
package decode_pkg;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned MAX_IN_W  = 8;
  localparam int unsigned MAX_OUT_W = 1 << MAX_IN_W;

  // One-hot of idx at the widest supported width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] idx);
    return MAX_OUT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/decode_onehot_scan_prescaler.sv
// Scan step prescaler: counts 0..div and issues one tick per period.
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset (cnt <= 0)
//   clr  in   clear counter, suppresses tick (mode change)
//   run  in   advance counter (enabled and in SCAN mode)
//   div  in   terminal count; tick period = div+1 clocks
//   tick out  combinational: cnt == div while running
// If div drops below cnt, cnt rolls over through zero before reaching div.
module scan_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_at_div;

  assign w_at_div = (r_cnt == div);
  assign tick     = run && !clr && w_at_div;

  // Counter: clear wins over run; holds when not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_at_div ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/decode_onehot_scan.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   output enable; 0 forces y inactive, idx/cnt hold
//   mode       in   0 = DECODE (load x on in_valid), 1 = SCAN (walk 0..scan_last)
//   x          in   index to decode
//   in_valid   in   x valid (DECODE only)
//   in_ready   out  combinational: 1 in DECODE, 0 in SCAN
//   div        in   prescaler terminal count; scan step every div+1 clocks
//   scan_last  in   last index of the scan ring
//   y          out  registered one-hot of idx
//   idx        out  registered current index
//   wrap       out  one-cycle pulse when the scan index wraps to 0
// Build option: DECODE_ONEHOT_SCAN_INVERT_EN makes y active-low
// (reset/disabled value all-ones, selected bit 0). idx/wrap unaffected.
// IN_W must not exceed decode_pkg::MAX_IN_W.
module decode_onehot_scan
  import decode_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [IN_W-1:0]      x,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIV_W-1:0]     div,
  input  logic [IN_W-1:0]      scan_last,
  output logic [(1<<IN_W)-1:0] y,
  output logic [IN_W-1:0]      idx,
  output logic                 wrap
);

  localparam int unsigned OUT_W = 1 << IN_W;

`ifdef DECODE_ONEHOT_SCAN_INVERT_EN
  localparam logic Y_INV = 1'b1;
`else
  localparam logic Y_INV = 1'b0;
`endif

  logic             r_mode_q;
  logic [IN_W-1:0]  r_idx;
  logic [OUT_W-1:0] r_y;
  logic             r_wrap;

  logic             w_mode_chg;
  logic             w_run;
  logic             w_tick;
  logic [IN_W-1:0]  w_idx_nxt;
  logic             w_wrap_nxt;
  logic [OUT_W-1:0] w_y_hot;
  logic [OUT_W-1:0] w_y_nxt;

  assign in_ready   = (mode == MODE_DECODE);
  assign w_mode_chg = (mode != r_mode_q);
  assign w_run      = en && (mode == MODE_SCAN);

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_mode_chg),
    .run  (w_run),
    .div  (div),
    .tick (w_tick)
  );

  // Next index: decode load or scan step; a mode-change cycle only holds.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_wrap_nxt = 1'b0;
    if (en && !w_mode_chg) begin
      if (mode == MODE_DECODE) begin
        if (in_valid) begin
          w_idx_nxt = x;
        end
      end else if (w_tick) begin
        // >= so a scan_last lowered below idx wraps on the next step.
        if (r_idx >= scan_last) begin
          w_idx_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IN_W'(1);
        end
      end
    end
  end

  // y tracks the next idx so both registers update on the same edge.
  assign w_y_hot = OUT_W'(onehot(MAX_IN_W'(w_idx_nxt)));
  assign w_y_nxt = (en ? w_y_hot : '0) ^ {OUT_W{Y_INV}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q <= MODE_DECODE;
      r_idx    <= '0;
      r_wrap   <= 1'b0;
      r_y      <= {OUT_W{Y_INV}};
    end else begin
      r_mode_q <= mode;
      r_idx    <= w_idx_nxt;
      r_wrap   <= w_wrap_nxt;
      r_y      <= w_y_nxt;
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_decode_onehot_scan.sv
module tb_decode_onehot_scan;

`ifdef DECODE_ONEHOT_SCAN_INVERT_EN
  localparam logic [15:0] YPOL = 16'hFFFF;
`else
  localparam logic [15:0] YPOL = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [3:0]  x;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] div;
  logic [3:0]  scan_last;
  logic [15:0] y;
  logic [3:0]  idx;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_onehot_scan #(.IN_W(4), .DIV_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div       (div),
    .scan_last (scan_last),
    .y         (y),
    .idx       (idx),
    .wrap      (wrap)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: integer index/counter, active-high y.
  bit          m_on = 1'b0;
  int          m_idx;
  int          m_cnt;
  bit          m_wrap;
  bit          m_modeq;
  logic [15:0] m_y;

  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_wrap = 0; m_modeq = 0; m_y = 16'h0;
      m_on = 1'b1;
    end else if (m_on) begin
      m_wrap = 0;
      if (mode != m_modeq) begin
        m_cnt = 0;
      end else if (en && mode) begin
        if (m_cnt == int'(div)) begin
          m_cnt = 0;
          if (m_idx >= int'(scan_last)) begin
            m_idx = 0;
            m_wrap = 1;
          end else begin
            m_idx = m_idx + 1;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else if (en && !mode && in_valid) begin
        m_idx = int'(x);
      end
      m_modeq = mode;
      m_y = en ? (16'h1 << m_idx) : 16'h0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_on) begin
      chk("y_model", 32'(y), 32'(m_y ^ YPOL));
      chk("idx_model", 32'(idx), 32'(m_idx));
      chk("wrap_model", 32'(wrap), 32'(m_wrap));
      chk("in_ready_model", 32'(in_ready), 32'(!mode));
    end
  end

  // Advance n clocks; inputs change 2 time units after each rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [3:0]  exp_idx [4];
  logic [15:0] exp_y   [4];

  initial begin
    exp_idx = '{4'd1, 4'd2, 4'd3, 4'd0};
    exp_y   = '{16'h0002, 16'h0004, 16'h0008, 16'h0001};

    // Reset with arbitrary inputs
    rst = 1; en = 1; mode = 1; x = 4'd5; in_valid = 1; div = 16'd0; scan_last = 4'd2;
    cyc(2);
    chk("reset_y", 32'(y), 32'(YPOL));
    chk("reset_idx", 32'(idx), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);

    rst = 0; mode = 0; in_valid = 0;
    cyc(1);

    // Decode 0xA, then hold
    x = 4'hA; in_valid = 1;
    cyc(1);
    chk("dec_y", 32'(y), 32'(16'h0400 ^ YPOL));
    chk("dec_idx", 32'(idx), 32'd10);
    in_valid = 0;
    cyc(3);
    chk("dec_hold_y", 32'(y), 32'(16'h0400 ^ YPOL));

    // Disabled: valid ignored, y off; re-enable restores
    en = 0; x = 4'd3; in_valid = 1;
    cyc(1);
    chk("dis_y", 32'(y), 32'(YPOL));
    chk("dis_idx", 32'(idx), 32'd10);
    in_valid = 0;
    cyc(2);
    en = 1;
    cyc(1);
    chk("reen_y", 32'(y), 32'(16'h0400 ^ YPOL));

    // Scan div=2, scan_last=3 from idx 0
    x = 4'd0; in_valid = 1;
    cyc(1);
    in_valid = 0; mode = 1; div = 16'd2; scan_last = 4'd3;
    cyc(1);
    chk("scan_start_idx", 32'(idx), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(2);
      chk("scan_wait_wrap", 32'(wrap), 32'd0);
      cyc(1);
      chk("scan_idx", 32'(idx), 32'(exp_idx[k]));
      chk("scan_y", 32'(y), 32'(exp_y[k] ^ YPOL));
      chk("scan_wrap", 32'(wrap), (k == 3) ? 32'd1 : 32'd0);
    end

    // div=0, idx=9, scan_last lowered to 5
    mode = 0;
    cyc(1);
    x = 4'd9; in_valid = 1;
    cyc(1);
    in_valid = 0; mode = 1; div = 16'd0; scan_last = 4'd15;
    cyc(1);
    chk("lower_pre_idx", 32'(idx), 32'd9);
    scan_last = 4'd5;
    cyc(1);
    chk("lower_idx", 32'(idx), 32'd0);
    chk("lower_wrap", 32'(wrap), 32'd1);
    cyc(1);
    chk("div0_idx", 32'(idx), 32'd1);
    chk("div0_wrap", 32'(wrap), 32'd0);
    cyc(4);
    chk("div0_idx5", 32'(idx), 32'd5);
    cyc(1);
    chk("div0_wrap2", 32'(wrap), 32'd1);

    // Mid-count switch to DECODE, then back to SCAN
    div = 16'd4; scan_last = 4'd15;
    cyc(1);
    mode = 0; x = 4'd7; in_valid = 1;
    cyc(1);
    chk("chg_hold_idx", 32'(idx), 32'd0);
    cyc(1);
    chk("chg_dec_idx", 32'(idx), 32'd7);
    chk("chg_dec_y", 32'(y), 32'(16'h0080 ^ YPOL));
    in_valid = 0; mode = 1;
    cyc(5);
    chk("resume_no_step", 32'(idx), 32'd7);
    cyc(1);
    chk("resume_step", 32'(idx), 32'd8);

    // Mixed traffic, div held fixed, checked by the model only
    div = 16'd1;
    for (int i = 0; i < 200; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      in_valid  = 1'($urandom);
      x         = 4'($urandom);
      if ($urandom_range(0, 5) == 0) scan_last = 4'($urandom);
      cyc(1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
